// File: rtl/fixed_arith_pkg.sv
// fixed_arith_pkg: shared widths, iteration count and FSM states for the fixed-point multiplier and divider
package fixed_arith_pkg;
  localparam int MCAND_W = 32;
  localparam int MPLIER_W = 16;
  localparam int PROD_W = 48;
  localparam int ITERS = 16;
  localparam int CNT_W = 5;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/fixed_multiplier_if.sv
// fixed_multiplier_if: request/result bundle for fixed_multiplier; inAddend exists only under FIXED_MULT_ACC_EN
interface fixed_multiplier_if;
  import fixed_arith_pkg::*;
  logic start;
  logic [MCAND_W-1:0] inMultiplicand;
  logic [MPLIER_W-1:0] inMultiplier;
  logic busy;
  logic done;
  logic [PROD_W-1:0] Product;
`ifdef FIXED_MULT_ACC_EN
  logic [MPLIER_W-1:0] inAddend;
  modport master (output start, inMultiplicand, inMultiplier, inAddend, input busy, done, Product);
  modport slave (input start, inMultiplicand, inMultiplier, inAddend, output busy, done, Product);
`else
  modport master (output start, inMultiplicand, inMultiplier, input busy, done, Product);
  modport slave (input start, inMultiplicand, inMultiplier, output busy, done, Product);
`endif
endinterface

// File: rtl/fixed_multiplier.sv
// fixed_multiplier: 16-cycle LSB-first shift-add multiplier, Product = M*Q (+A when FIXED_MULT_ACC_EN)
module fixed_multiplier (
  input logic clock,
  input logic reset,
  fixed_multiplier_if.slave bus
);
  import fixed_arith_pkg::*;
  state_t state, state_nx;
  logic [PROD_W-1:0] mc, acc, acc_nx, acc_init, product;
  logic [MPLIER_W-1:0] mq;
  logic [CNT_W-1:0] cnt;
  logic last, accept;
`ifdef FIXED_MULT_ACC_EN
  assign acc_init = PROD_W'(bus.inAddend);
`else
  assign acc_init = '0;
`endif
  // multiplicand shifts left and multiplier right, so bit 0 always selects the current partial product
  assign acc_nx = acc + (mq[0] ? mc : '0);
  assign last = cnt == CNT_W'(ITERS - 1);
  assign accept = state == IDLE && bus.start;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (bus.start ? RUN : IDLE) :
               state == RUN  ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clock)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clock)
    if (reset) begin
      mc <= '0;
      mq <= '0;
      acc <= '0;
      cnt <= '0;
      product <= '0;
    end else if (accept) begin
      mc <= PROD_W'(bus.inMultiplicand);
      mq <= bus.inMultiplier;
      acc <= acc_init;
      cnt <= '0;
    end else if (state == RUN) begin
      mc <= mc << 1;
      mq <= mq >> 1;
      acc <= acc_nx;
      cnt <= cnt + CNT_W'(1);
      if (last) product <= acc_nx;
    end
  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;
  assign bus.Product = product;
endmodule

// File: tb/tb_fixed_multiplier.sv
// tb_fixed_multiplier: directed vectors plus random operands, checked by a queue-based scoreboard
module tb_fixed_multiplier;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  logic [47:0] exp_q[$];
  int t_q[$];
  fixed_multiplier_if bus();
  fixed_multiplier dut (.clock(clock), .reset(reset), .bus(bus.slave));
`ifdef FIXED_MULT_ACC_EN
  logic [15:0] addend = '0;
  assign bus.inAddend = addend;
`endif
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  logic busy_d = 1'b0;
  int busy_n = 0;
  logic [47:0] prod_run = '0;
  always @(negedge clock) begin
    if (bus.busy && !busy_d) begin
      busy_n = 0;
      prod_run = bus.Product;
    end
    if (bus.busy) begin
      busy_n++;
      chk("product_stable_in_run", bus.Product, prod_run);
    end
    if (bus.done) begin
      if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        chk("product", bus.Product, exp_q.pop_front());
        chk("latency", cyc - t_q.pop_front(), 17);
        chk("busy_cycles", busy_n, 16);
      end
    end
    busy_d = bus.busy;
  end

  task automatic wait_idle();
    int n = 0;
    while ((bus.busy || bus.done) && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) chk("idle_timeout", 1, 0);
  endtask

  task automatic issue(input logic [31:0] m, input logic [15:0] q, input logic [47:0] e, input bit push, output int t);
    wait_idle();
    bus.start = 1'b1;
    bus.inMultiplicand = m;
    bus.inMultiplier = q;
    t = cyc;
    if (push) begin
      exp_q.push_back(e);
      t_q.push_back(cyc);
    end
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.busy || bus.done) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) chk("drain_timeout", 1, 0);
  endtask

  typedef struct {
    logic [31:0] m;
    logic [15:0] q;
    logic [47:0] e;
  } vec_t;
  vec_t vecs[6] = '{
    '{32'h0001_0000, 16'h0003, 48'h0000_0003_0000},
    '{32'hFFFF_FFFF, 16'hFFFF, 48'hFFFE_FFFF_0001},
    '{32'h8000_0000, 16'h8000, 48'h4000_0000_0000},
    '{32'd12345,     16'd100,  48'h0000_0012_D644},
    '{32'h0000_0000, 16'hFFFF, 48'h0000_0000_0000},
    '{32'h0000_0001, 16'h0001, 48'h0000_0000_0001}
  };

  initial begin
    int t, t1, t2;
    logic [31:0] m;
    logic [15:0] q, a;
    logic [63:0] p;
    bus.start = 1'b0;
    bus.inMultiplicand = '0;
    bus.inMultiplier = '0;
    repeat (3) @(negedge clock);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_product", bus.Product, 0);
    reset = 1'b0;
    foreach (vecs[i]) issue(vecs[i].m, vecs[i].q, vecs[i].e, 1'b1, t);
    drain();
    repeat (3) @(negedge clock);
    chk("product_hold_idle", bus.Product, 48'h0000_0000_0001);
    issue(32'h1234_5678, 16'h0000, 48'h0, 1'b1, t1);
    issue(32'h0000_0002, 16'h0005, 48'hA, 1'b1, t2);
    chk("back_to_back_interval", t2 - t1, 18);
    drain();
`ifdef FIXED_MULT_ACC_EN
    addend = 16'hFFFF;
    issue(32'hFFFF_FFFF, 16'hFFFF, 48'hFFFF_0000_0000, 1'b1, t);
    addend = 16'd4;
    issue(32'h0002_2E09, 16'd7, 48'h0000_000F_4243, 1'b1, t);
    drain();
    addend = '0;
`endif
    issue(32'h0000_1000, 16'h0010, 48'h0000_0001_0000, 1'b1, t);
    repeat (5) @(negedge clock);
    bus.start = 1'b1;
    bus.inMultiplicand = 32'hFFFF_FFFF;
    bus.inMultiplier = 16'hFFFF;
    @(negedge clock);
    bus.start = 1'b0;
    drain();
    repeat (5) @(negedge clock);
    issue(32'hDEAD_BEEF, 16'hFFFF, 48'h0, 1'b0, t);
    repeat (8) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_product", bus.Product, 0);
    repeat (25) @(negedge clock);
    chk("abort_still_idle", {bus.busy, bus.done}, 0);
    for (int i = 0; i < 2000; i++) begin
      m = $urandom;
      q = 16'($urandom_range(0, 65535));
      a = '0;
`ifdef FIXED_MULT_ACC_EN
      a = 16'($urandom);
      addend = a;
`endif
      p = 64'(m) * 64'(q) + 64'(a);
      issue(m, q, p[47:0], 1'b1, t);
    end
    drain();
    chk("queue_empty", 64'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
